// File: rtl/sub_pkg.sv
// ============================================================================
// sub_pkg : shared state encoding and sizing helpers for serial_subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Counter must be able to hold the step count itself, not just STEPS-1.
    function automatic int cnt_width(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_digit.sv
// ============================================================================
// sub_digit : combinational DIGIT-bit ripple-borrow subtractor slice
// Rev 1.0
// ============================================================================
`default_nettype none

module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             br_in,
    output logic [DIGIT-1:0] d,
    output logic             br_out
);

    logic [DIGIT:0] w_chain;

    assign w_chain[0] = br_in;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            assign d[i]         = x[i] ^ y[i] ^ w_chain[i];
            assign w_chain[i+1] = (~x[i] & y[i]) | (~x[i] & w_chain[i]) | (y[i] & w_chain[i]);
        end
    endgenerate

    assign br_out = w_chain[DIGIT];

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : digit-serial A - B - B_in with start/done handshake,
//                     borrow-out and signed-overflow flags
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    sub_state_t              r_state;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic [WIDTH-1:0]        r_res;
    logic                    r_br;
    logic [CW-1:0]           r_cnt;
    logic                    r_a_msb;
    logic                    r_b_msb;

    logic [DIGIT-1:0]        w_d;
    logic                    w_br;
    logic [WIDTH+DIGIT-1:0]  w_cat;
    logic [WIDTH-1:0]        w_res_next;
    logic                    w_last;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x      (r_a[DIGIT-1:0]),
        .y      (r_b[DIGIT-1:0]),
        .br_in  (r_br),
        .d      (w_d),
        .br_out (w_br)
    );

    // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0.
    assign w_cat      = {w_d, r_res};
    assign w_res_next = w_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_last     = (r_cnt == CW'(STEPS - 1));

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            diff    <= '0;
            b_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= b_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_res <= w_res_next;
                    r_br  <= w_br;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        diff    <= w_res_next;
                        b_out   <= w_br;
                        ovf     <= (r_a_msb ^ r_b_msb) & (w_res_next[WIDTH-1] ^ r_a_msb);
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed vectors, handshake corner cases and a
//                        4-bit exhaustive sweep for DIGIT in {1,2,4}
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       start, bin;
    logic [7:0] a, b;
    logic       busy, done, bo, ovf;
    logic [7:0] diff;

    logic       start_q;
    logic       busy_q, done_q, bo_q, ovf_q;
    logic [7:0] diff_q;

    logic       start_s, bin_s;
    logic [3:0] a_s, b_s;
    logic       busy_s [3];
    logic       done_s [3];
    logic       bo_s   [3];
    logic       ovf_s  [3];
    logic [3:0] diff_s [3];

    int passed = 0;
    int total  = 0;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(bin),
        .busy(busy), .done(done), .diff(diff), .b_out(bo), .ovf(ovf)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_q), .a(a), .b(b), .b_in(bin),
        .busy(busy_q), .done(done_q), .diff(diff_q), .b_out(bo_q), .ovf(ovf_q)
    );

    generate
        for (genvar g = 0; g < 3; g++) begin : g_sweep
            serial_subtractor #(.WIDTH(4), .DIGIT(1 << g)) u_sw (
                .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s), .b_in(bin_s),
                .busy(busy_s[g]), .done(done_s[g]), .diff(diff_s[g]),
                .b_out(bo_s[g]), .ovf(ovf_s[g])
            );
        end
    endgenerate

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bo;
        logic       ovf;
        string      name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic run8(input vec_t v);
        int lat;
        int nbusy;
        a = v.a; b = v.b; bin = v.bin; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        lat = 1; nbusy = 0;
        while (!done && lat <= 20) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        check({v.name, "_latency"}, lat, 9);
        check({v.name, "_busy_cycles"}, nbusy, 8);
        check({v.name, "_diff"}, diff, v.diff);
        check({v.name, "_b_out"}, bo, v.bo);
        check({v.name, "_ovf"}, ovf, v.ovf);
        tick();
        check({v.name, "_done_pulse"}, done, 0);
        check({v.name, "_diff_hold"}, diff, v.diff);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int lat;
        logic got [3];
        logic [4:0] r;
        logic [3:0] ed;
        logic eo;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "v_5m3"};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "v_0m1"};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "v_0m0b"};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "v_80m1"};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "v_7Fm_FF"};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "v_FFmFFb"};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, "v_A5m5A"};
        vecs[7] = '{8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0, 1'b0, "v_3Cm0Fb"};

        rst = 1'b1; start = 1'b1; start_q = 1'b0; start_s = 1'b0;
        a = 8'h55; b = 8'h11; bin = 1'b0; a_s = '0; b_s = '0; bin_s = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_b_out", bo, 0);
        check("rst_ovf", ovf, 0);
        check("rst_q_busy_done", {busy_q, done_q}, 0);
        check("rst_sweep_busy", {busy_s[0], busy_s[1], busy_s[2]}, 0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run8(vecs[i]);

        // start pulsed mid-RUN must not re-capture
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done8(20, n);
        check("ignore_latency", 4 + n, 9);
        check("ignore_diff", diff, 8'h02);
        check("ignore_flags", {bo, ovf}, 0);
        tick(); tick();

        // start held high: back-to-back results
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        tick();
        wait_done8(20, n);
        check("b2b_first_latency", 1 + n, 9);
        check("b2b_first_diff", diff, 8'h0F);
        tick();
        start = 1'b0;
        check("b2b_reaccept_busy", busy, 1);
        wait_done8(20, n);
        check("b2b_gap", 1 + n, 9);
        check("b2b_second_diff", diff, 8'h0F);
        tick();
        check("b2b_idle_after", {busy, done}, 0);

        // reset in the middle of an operation
        run8(vecs[3]);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_b_out", bo, 0);
        check("abort_ovf", ovf, 0);
        wait_done8(12, n);
        check("abort_no_done", done, 0);
        run8('{8'h64, 8'h32, 1'b0, 8'h32, 1'b0, 1'b0, "v_after_abort"});

        // DIGIT=4 unit
        a = 8'h3C; b = 8'h0F; bin = 1'b0; start_q = 1'b1;
        tick();
        start_q = 1'b0;
        lat = 1;
        while (!done_q && lat <= 10) begin
            tick();
            lat++;
        end
        check("d4_latency", lat, 3);
        check("d4_diff", diff_q, 8'h2D);
        check("d4_flags", {bo_q, ovf_q}, 0);
        tick();
        check("d4_done_pulse", done_q, 0);

        // exhaustive 4-bit sweep across DIGIT = 1, 2, 4
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a_s = 4'(ia); b_s = 4'(ib); bin_s = 1'(ic); start_s = 1'b1;
                    r  = {1'b0, a_s} - {1'b0, b_s} - {4'b0, bin_s};
                    ed = r[3:0];
                    eo = (a_s[3] ^ b_s[3]) & (ed[3] ^ a_s[3]);
                    tick();
                    start_s = 1'b0;
                    for (int g = 0; g < 3; g++) got[g] = 1'b0;
                    for (int t = 1; t <= 6; t++) begin
                        for (int g = 0; g < 3; g++) begin
                            if (done_s[g] && !got[g]) begin
                                got[g] = 1'b1;
                                check($sformatf("sweep_d%0d_lat_%0h_%0h_%0d", 1 << g, ia, ib, ic),
                                      t, (4 >> g) + 1);
                                check($sformatf("sweep_d%0d_res_%0h_%0h_%0d", 1 << g, ia, ib, ic),
                                      {bo_s[g], ovf_s[g], diff_s[g]}, {r[4], eo, ed});
                            end
                        end
                        tick();
                    end
                    for (int g = 0; g < 3; g++)
                        if (!got[g]) check($sformatf("sweep_d%0d_timeout", 1 << g), 0, 1);
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
